// File: rtl/alu_cmd_sequencer.sv
// Host-side command sequencer for the 16-bit accumulator ALU breadboard.
// Buffers commands, issues each one for a single clock, captures the accumulator and returns it with an error code.
module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [3:0]        CMD_OP,
  input  logic [15:0]       CMD_IN,
  output logic [3:0]        OP,
  output logic [15:0]       IN,
  input  logic [31:0]       OUT,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [31:0]       RSP_DATA,
  output logic [1:0]        RSP_ERR,
  output logic              BUSY,
  output logic [ADDR_W:0]   CMD_COUNT
);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, RESPOND} state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(FIFO_DEPTH);

  state_t              state_q, state_d;
  logic [3:0]          op_mem [FIFO_DEPTH];
  logic [15:0]         in_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W:0]     count;
  logic                push, pop;
  logic [3:0]          op_d;
  logic [15:0]         in_d;
  logic [1:0]          err_p1;

  // Error code is judged against the pre-op accumulator fed back on OUT[15:0].
  function automatic logic [1:0] calc_err(input logic [3:0] op, input logic [15:0] opnd,
                                          input logic [15:0] fb);
    logic [1:0] e;
    e = 2'b00;
    if (op == 4'b0011 && opnd > fb) e[0] = 1'b1;
    if ((op == 4'b0101 || op == 4'b0110) && opnd == 16'h0000) e[1] = 1'b1;
    return e;
  endfunction

  assign CMD_READY = (count != FULL_CNT);
  assign push      = CMD_VALID & CMD_READY;
  assign CMD_COUNT = count;
  assign BUSY      = (state_q != IDLE) || (count != '0);
  assign RSP_VALID = (state_q == RESPOND);

  // Command FIFO storage
  always_ff @(posedge CLK) begin
    if (push) begin
      op_mem[wr_ptr] <= CMD_OP;
      in_mem[wr_ptr] <= CMD_IN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer next state; OP/IN only move on a state transition
  always_comb begin
    state_d = state_q;
    op_d    = OP;
    in_d    = IN;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          op_d    = op_mem[rd_ptr];
          in_d    = in_mem[rd_ptr];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        op_d    = 4'b0000;
        in_d    = 16'h0000;
        state_d = SETTLE;
      end
      SETTLE:  state_d = RESPOND;
      RESPOND: if (RSP_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Breadboard drive, pending error and response capture
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      OP       <= 4'b0000;
      IN       <= 16'h0000;
      err_p1   <= 2'b00;
      RSP_DATA <= 32'h0;
      RSP_ERR  <= 2'b00;
    end else begin
      state_q <= state_d;
      OP      <= op_d;
      IN      <= in_d;
      if (state_q == ISSUE) err_p1 <= calc_err(OP, IN, OUT[15:0]);
      if (state_q == SETTLE) begin
        RSP_DATA <= OUT;
        RSP_ERR  <= err_p1;
      end
    end
  end

endmodule
